// File: rtl/usb_hid_pkg.sv
// Shared definitions for the USB HID keyboard OUT-report receive path.
package usb_hid_pkg;

    localparam int LED_NUM     = 0;
    localparam int LED_CAPS    = 1;
    localparam int LED_SCROLL  = 2;
    localparam int LED_COMPOSE = 3;
    localparam int LED_KANA    = 4;
    localparam int LED_W       = LED_KANA + 1;

    localparam int GAP_CYCLES_DEFAULT = 200;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DONE    = 2'd2,
        DISCARD = 2'd3
    } rx_state_t;

endpackage

// File: rtl/usb_idle_gap_timer.sv
// Idle-gap counter: counts enabled cycles since the last clear and flags when
// GAP_CYCLES-1 has been reached; saturates there until cleared.
module usb_idle_gap_timer #(
    parameter int GAP_CYCLES = 200,
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;

    assign expire_o = (gap_q == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        gap_d = gap_q;
        if (clr_i) begin
            gap_d = '0;
        end else if (en_i && !expire_o) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/usb_hid_out_report_rx.sv
// HID OUT-endpoint receiver: delimits packets by idle gap, buffers them,
// reports each completed packet and latches the keyboard LED byte.
module usb_hid_out_report_rx
    import usb_hid_pkg::*;
#(
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int REPORT_LEN = 1,
    localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   usb_rstn,
    input  logic [7:0]             out_data,
    input  logic                   out_valid,
    output logic [8*MAX_LEN-1:0]   report_data,
    output logic [CNT_W-1:0]       report_len,
    output logic                   report_valid,
    output logic [LED_W-1:0]       led,
    output logic                   err_overflow,
    output logic                   err_len
);

    rx_state_t state_q, state_d;

    logic [MAX_LEN-1:0][7:0] pkt_q;
    logic [MAX_LEN-1:0][7:0] report_data_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        report_len_q;
    logic [LED_W-1:0]        led_q;
    logic                    report_valid_q;
    logic                    err_overflow_q;
    logic                    err_len_q;

    logic gap_expire;
    logic gap_clr;
    logic buf_full;
    logic start_pkt;
    logic close_pkt;

    assign buf_full  = (cnt_q == CNT_W'(MAX_LEN));
    assign start_pkt = out_valid && (state_q == IDLE || state_q == DONE);
    assign close_pkt = (state_q == RECV) && (state_d == DONE);

    // Gap counts only while a packet is open; any byte restarts it.
    assign gap_clr = !usb_rstn || out_valid || !(state_q == RECV || state_q == DISCARD);

    usb_idle_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (gap_clr),
        .en_i     (1'b1),
        .expire_o (gap_expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (out_valid) state_d = RECV;
            end
            RECV: begin
                if (out_valid) begin
                    if (buf_full) state_d = DISCARD;
                end else if (gap_expire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = out_valid ? RECV : IDLE;
            end
            DISCARD: begin
                if (!out_valid && gap_expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else if (!usb_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_q          <= '0;
            cnt_q          <= '0;
            report_data_q  <= '0;
            report_len_q   <= '0;
            led_q          <= '0;
            report_valid_q <= 1'b0;
            err_overflow_q <= 1'b0;
            err_len_q      <= 1'b0;
        end else if (!usb_rstn) begin
            pkt_q          <= '0;
            cnt_q          <= '0;
            report_data_q  <= '0;
            report_len_q   <= '0;
            led_q          <= '0;
            report_valid_q <= 1'b0;
            err_overflow_q <= 1'b0;
            err_len_q      <= 1'b0;
        end else begin
            report_valid_q <= 1'b0;
            err_overflow_q <= 1'b0;
            err_len_q      <= 1'b0;

            if (start_pkt) begin
                pkt_q    <= '0;
                pkt_q[0] <= out_data;
                cnt_q    <= CNT_W'(1);
            end else if (state_q == RECV && out_valid) begin
                if (buf_full) begin
                    err_overflow_q <= 1'b1;
                end else begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) pkt_q[i] <= out_data;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            if (close_pkt) begin
                report_valid_q <= 1'b1;
                err_len_q      <= (cnt_q != CNT_W'(REPORT_LEN));
                report_len_q   <= cnt_q;
                report_data_q  <= pkt_q;
            end

            // LED latch happens on the DONE edge; pkt_q still holds the closed packet here.
            if (state_q == DONE && cnt_q == CNT_W'(REPORT_LEN)) begin
                led_q <= pkt_q[0][LED_KANA:LED_NUM];
            end
        end
    end

    assign report_data  = report_data_q;
    assign report_len   = report_len_q;
    assign report_valid = report_valid_q;
    assign led          = led_q;
    assign err_overflow = err_overflow_q;
    assign err_len      = err_len_q;

endmodule

// File: doc/usb_hid_out_report_rx.md
Name: usb_hid_out_report_rx

Overview:
- Receiver for the host-to-device (OUT) direction of the USB HID keyboard.
- Consumes the byte stream that usbfs_core_top delivers on out_data/out_valid.
- Delimits packets using an idle-gap timeout, buffers up to MAX_LEN bytes, validates the report length, and latches the keyboard LED output report (NumLock/CapsLock/ScrollLock/Compose/Kana) for board LEDs.
- Sits beside the keyboard IN-report logic inside the HID top level.

Parameters:
- MAX_LEN, 8: maximum packet bytes buffered; matches OUT endpoint max packet size; range 1..15.
- GAP_CYCLES, 200: consecutive idle clk cycles (no out_valid) that close a packet; must exceed the worst-case 60MHz inter-byte spacing (~40 cycles); range 2..1023.
- REPORT_LEN, 1: packet length, in bytes, accepted as a valid LED output report.

Ports:
- clk  in  1  60MHz system clock
- rstn  in  1  reset; asynchronous, active-low
- usb_rstn  in  1  USB bus-reset from core, active-low; synchronous clear
- out_data  in  8  OUT payload byte from core
- out_valid  in  1  out_data valid, single-cycle per byte; no backpressure
- report_data  out  8*MAX_LEN  packet bytes, byte i at [8i+7:8i]; bytes beyond report_len are 0
- report_len  out  $clog2(MAX_LEN+1)  byte count of last completed packet
- report_valid  out  1  one-cycle pulse: packet completed; report_data/report_len stable from this cycle until the next packet's first byte
- led  out  5  latched byte0[4:0] of last valid report; bit0 NumLock, bit1 CapsLock, bit2 ScrollLock, bit3 Compose, bit4 Kana
- err_overflow  out  1  one-cycle pulse: byte arrived with buffer already full
- err_len  out  1  one-cycle pulse: completed packet length != REPORT_LEN

Behaviour:
- Reset: rstn=0 asynchronously clears all outputs and state to 0; state=IDLE.
- Bus reset: usb_rstn=0 at a clk edge has the same effect synchronously; it overrides out_valid.
- States: IDLE, RECV, DONE, DISCARD.
- Counters:
  - cnt: width $clog2(MAX_LEN+1); bytes stored.
  - gap: width $clog2(GAP_CYCLES+1); idle cycles.
- IDLE:
  - On out_valid: buf[0]<=out_data; clear buf[1..MAX_LEN-1]; cnt<=1; gap<=0; go RECV.
- RECV:
  - out_valid with cnt<MAX_LEN: buf[cnt]<=out_data; cnt++; gap<=0.
  - out_valid with cnt==MAX_LEN: err_overflow pulse next cycle; gap<=0; go DISCARD.
  - No out_valid: gap++. When gap reaches GAP_CYCLES-1 with no byte this cycle, go DONE. A packet therefore closes GAP_CYCLES idle cycles after its last byte.
- DONE (exactly one cycle):
  - report_valid=1; report_len=cnt; report_data=buf.
  - If cnt==REPORT_LEN: led<=buf[0][4:0] (visible next cycle).
  - Else: err_len=1; led unchanged.
  - If out_valid is also high in this cycle, that byte starts a new packet exactly as in IDLE (go RECV); otherwise go IDLE.
- DISCARD:
  - Bytes ignored; each out_valid resets gap.
  - Gap expiry goes to IDLE with no report_valid and no led update.
  - report_data/report_len keep their previous values.
- Output registering: report_valid, err_len and err_overflow are registered pulses, never high two consecutive cycles for the same event.
- Latency: report_valid rises GAP_CYCLES+1 cycles after the last byte's out_valid cycle.
- Timing rule: byte arrival does not depend on any ready signal; a byte is never dropped in IDLE/RECV/DONE.

Decomposition:
- usb_hid_pkg holds:
  - LED bit index constants: LED_NUM=0, LED_CAPS=1, LED_SCROLL=2, LED_COMPOSE=3, LED_KANA=4.
  - State enum rx_state_t {IDLE, RECV, DONE, DISCARD}.
  - Default GAP_CYCLES constant.
- One sub-module, usb_idle_gap_timer (loadable counter with clear/expire), is natural and reusable for any packet-delimited OUT endpoint.

Test Plan:
- Single byte 8'h02, then idle → report_valid after GAP_CYCLES+1 cycles; report_len=1; led=5'b00010 (CapsLock); no error pulses.
- Two-byte packet 8'h01,8'h07 (40 cycles apart) → report_valid, report_len=2, report_data[15:0]=16'h0701, err_len=1, led unchanged.
- 9 bytes back-to-back with MAX_LEN=8 → err_overflow one pulse on 9th byte; no report_valid; led unchanged; next 1-byte packet 8'h05 → led=5'b00101.
- Byte 8'h04 arrives exactly in the DONE cycle of a previous 1-byte 8'h01 report → led=5'b00001 then, after its gap, led=5'b00100; two report_valid pulses.
- usb_rstn pulsed low mid-packet after 3 bytes → led=0, report_len=0, no report_valid; following 1-byte 8'h1F report → led=5'b11111.
- rstn asserted asynchronously between clk edges while in RECV → all outputs 0 immediately, state IDLE on release.
